// File: rtl/testport_if.sv
// Signal bundle between the result source, the frame controller and the D-side
// write bus of the test-port writer. "master" is the writer, "slave" its environment.
interface testport_if;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        busy;
  logic        done;
  logic [9:0]  word_cnt;

  modport master (
    input  start, in_valid, in_data, stall,
    output in_ready, addr, data, wen, busy, done, word_cnt
  );

  modport slave (
    output start, in_valid, in_data, stall,
    input  in_ready, addr, data, wen, busy, done, word_cnt
  );
endinterface

// File: rtl/testport_writer.sv
// Test-port frame writer: BEGIN_SYM, NUM_WORDS buffered result words, END_SYM as
// byte-swapped writes to TEST_PORT. Define TESTPORT_CHECKSUM_EN to add a checksum word before END.
module testport_writer #(
  parameter logic [29:0] TEST_PORT  = 30'h3FF,
  parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
  parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
  parameter int          NUM_WORDS  = 160,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  testport_if.master bus
);

  localparam int         AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [9:0] NUM_WORDS_C = 10'(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEGIN = 3'd1,
    S_GAP   = 3'd2,
    S_DATA  = 3'd3,
    S_END   = 3'd4,
    S_DONE  = 3'd5
`ifdef TESTPORT_CHECKSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic is_write(input state_t s);
    logic w;
    case (s)
      S_BEGIN, S_DATA, S_END: w = 1'b1;
`ifdef TESTPORT_CHECKSUM_EN
      S_CSUM:                 w = 1'b1;
`endif
      default:                w = 1'b0;
    endcase
    return w;
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic [31:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic [31:0] fifo_head_s;
  logic        push_s;
  logic        pop_s;
  logic        start_s;
  logic        accept_s;

  logic [29:0] addr_r;
  logic [31:0] data_r;
  logic        wen_r;
  logic        busy_r;
  logic        done_r;
  logic [9:0]  word_cnt_r;

`ifdef TESTPORT_CHECKSUM_EN
  logic [31:0] csum_r;
  logic        csum_sent_r;
`endif

  assign bus.in_ready = ~fifo_full_s & busy_r;
  assign bus.addr     = addr_r;
  assign bus.data     = data_r;
  assign bus.wen      = wen_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.word_cnt = word_cnt_r;

  // FIFO status: full is judged on the registered pointers only, so a same-cycle pop never frees a slot.
  always_comb begin
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    fifo_head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];
    push_s       = bus.in_valid & ~fifo_full_s & busy_r;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= bus.in_data;
    end
  end

  // FIFO pointers; a new frame discards anything left over from the last one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (start_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Next-state logic; the FIFO pop is issued on the GAP -> DATA transition
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    start_s      = 1'b0;
    accept_s     = wen_r & ~bus.stall;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          next_state_s = S_BEGIN;
          start_s      = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      S_BEGIN, S_DATA: begin
        if (accept_s) begin
          next_state_s = S_GAP;
        end else begin
          next_state_s = state_r;
        end
      end
      S_GAP: begin
        if (word_cnt_r == NUM_WORDS_C) begin
`ifdef TESTPORT_CHECKSUM_EN
          if (csum_sent_r) begin
            next_state_s = S_END;
          end else begin
            next_state_s = S_CSUM;
          end
`else
          next_state_s = S_END;
`endif
        end else if ((word_cnt_r < NUM_WORDS_C) && !fifo_empty_s) begin
          next_state_s = S_DATA;
          pop_s        = 1'b1;
        end else begin
          next_state_s = S_GAP;
        end
      end
`ifdef TESTPORT_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          next_state_s = S_GAP;
        end else begin
          next_state_s = S_CSUM;
        end
      end
`endif
      S_END: begin
        if (accept_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_END;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State and bus registers; addr/data load only on entry to a write state, so a stall holds them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      wen_r   <= 1'b0;
      addr_r  <= 30'd0;
      data_r  <= 32'd0;
    end else begin
      state_r <= next_state_s;
      wen_r   <= is_write(next_state_s);
      if (next_state_s != state_r) begin
        case (next_state_s)
          S_BEGIN: begin
            addr_r <= TEST_PORT;
            data_r <= bswap(BEGIN_SYM);
          end
          S_DATA: begin
            addr_r <= TEST_PORT;
            data_r <= bswap(fifo_head_s);
          end
`ifdef TESTPORT_CHECKSUM_EN
          S_CSUM: begin
            addr_r <= TEST_PORT;
            data_r <= bswap(csum_r);
          end
`endif
          S_END: begin
            addr_r <= TEST_PORT;
            data_r <= bswap(END_SYM);
          end
          default: begin
            addr_r <= addr_r;
            data_r <= data_r;
          end
        endcase
      end
    end
  end

  // Frame status: busy/done levels and the count of data words the bus has taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      word_cnt_r <= 10'd0;
    end else if (start_s) begin
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      word_cnt_r <= 10'd0;
    end else begin
      if ((state_r == S_DATA) && accept_s) begin
        word_cnt_r <= word_cnt_r + 10'd1;
      end
      if ((state_r == S_END) && accept_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

`ifdef TESTPORT_CHECKSUM_EN
  // Running sum of readable-order words, taken as each word leaves the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_r      <= 32'd0;
      csum_sent_r <= 1'b0;
    end else if (start_s) begin
      csum_r      <= 32'd0;
      csum_sent_r <= 1'b0;
    end else begin
      if (pop_s) begin
        csum_r <= csum_r + fifo_head_s;
      end
      if ((state_r == S_CSUM) && accept_s) begin
        csum_sent_r <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_testport_writer.sv
// Scoreboard bench for testport_writer: expected bus words are queued at frame
// start and a negedge monitor checks every accepted write against the queue.
module tb_testport_writer;
  logic clk;
  logic rst;

  testport_if bus();

  testport_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q [$];
  logic [31:0] src_q [$];
  bit          hold_armed;
  logic [31:0] hold_word;
  bit          prev_acc;
`ifdef TESTPORT_CHECKSUM_EN
  logic [31:0] csum_next;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

`ifdef TESTPORT_CHECKSUM_EN
  function automatic logic [31:0] frame_sum(input logic [31:0] base);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 160; i++) s = s + base + 32'(i);
    return s;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wen"},      32'(bus.wen),      32'd0);
    check({tag, "_addr"},     32'(bus.addr),     32'd0);
    check({tag, "_data"},     bus.data,          32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  // Called at posedge+2: queue the expected frame and the source words, then pulse start.
  task automatic start_frame(input string tag, input logic [31:0] base);
    exp_q.push_back(32'h68010000);
    for (int i = 0; i < 160; i++) begin
      exp_q.push_back(swap32(base + 32'(i)));
      src_q.push_back(base + 32'(i));
    end
`ifdef TESTPORT_CHECKSUM_EN
    exp_q.push_back(csum_next);
`endif
    exp_q.push_back(32'h5DFDFFFF);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    check({tag, "_start_busy"},  32'(bus.busy),     32'd1);
    check({tag, "_start_done"},  32'(bus.done),     32'd0);
    check({tag, "_start_wcnt"},  32'(bus.word_cnt), 32'd0);
  endtask

  task automatic wait_cnt(input string tag, input logic [9:0] n, input bit gap);
    int k;
    k = 0;
    while (!((bus.word_cnt == n) && (!gap || (bus.wen == 1'b0))) && (k < 2000)) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: word_cnt %0d, waited for %0d", tag, bus.word_cnt, n);
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((bus.done !== 1'b1) && (k < 3000)) begin
      @(posedge clk); #2;
      k++;
    end
    check({tag, "_done"},     32'(bus.done),     32'd1);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_wen"},      32'(bus.wen),      32'd0);
    check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'd160);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Source: presents the head of src_q, retiring it once a handshake was seen
  initial begin
    bit pushed;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    forever begin
      @(negedge clk);
      pushed = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      @(posedge clk); #1;
      if (pushed && (src_q.size() > 0)) void'(src_q.pop_front());
      if ((src_q.size() > 0) && !(hold_armed && (src_q[0] == hold_word))) begin
        bus.in_valid = 1'b1;
        bus.in_data  = src_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
      end
    end
  end

  // Monitor: every accepted write must match the queue; wen must drop after each one
  initial begin
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_acc) check("wen_gap", 32'(bus.wen), 32'd0);
      prev_acc = (bus.wen === 1'b1) && (bus.stall === 1'b0);
      if (prev_acc) begin
        check("addr", 32'(bus.addr), 32'h000003FF);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got %h, expected no write", bus.data);
        end else begin
          check("data", bus.data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.stall  = 1'b0;
    hold_armed = 1'b0;
    hold_word  = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    rst = 1'b1;
    @(posedge clk); #2;

    // Frame 1: words 0..159, no stall; a start while busy must be ignored
`ifdef TESTPORT_CHECKSUM_EN
    csum_next = swap32(frame_sum(32'd0));
`endif
    start_frame("f1", 32'd0);
    repeat (30) @(posedge clk);
    #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    check("f1_restart_busy", 32'(bus.busy), 32'd1);
    wait_done("f1");

    // Frame 2: source ahead under stall, stall on data write 3, source gap after word 50
`ifdef TESTPORT_CHECKSUM_EN
    csum_next = swap32(frame_sum(32'h0A0B0C00));
`endif
    hold_word  = 32'h0A0B0C00 + 32'd51;
    hold_armed = 1'b1;
    bus.stall  = 1'b1;
    start_frame("f2", 32'h0A0B0C00);
    repeat (8) @(posedge clk);
    #2;
    check("full_in_ready",  32'(bus.in_ready), 32'd0);
    check("full_pushed",    32'(src_q.size()), 32'd156);
    check("full_wen_held",  32'(bus.wen),      32'd1);
    check("full_data_held", bus.data,          32'h68010000);
    check("full_word_cnt",  32'(bus.word_cnt), 32'd0);
    bus.stall = 1'b0;

    wait_cnt("stall3", 10'd2, 1'b1);
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_wen",  32'(bus.wen),  32'd1);
      check("stall_addr", 32'(bus.addr), 32'h000003FF);
      check("stall_data", bus.data,      32'h020C0B0A);
    end
    @(posedge clk); #2;
    bus.stall = 1'b0;

    wait_cnt("gap51", 10'd51, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("empty_wen", 32'(bus.wen), 32'd0);
    end
    check("empty_word_cnt", 32'(bus.word_cnt), 32'd51);
    check("empty_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #2;
    hold_armed = 1'b0;
    wait_done("f2");

    // Frame 3: asynchronous reset at word 80
`ifdef TESTPORT_CHECKSUM_EN
    csum_next = swap32(frame_sum(32'hDEAD0000));
`endif
    start_frame("f3", 32'hDEAD0000);
    wait_cnt("rst80", 10'd80, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_reset("midrst");
    exp_q.delete();
    src_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    check_reset("postrst");

    // Frame 4: words 1..160 after reset
`ifdef TESTPORT_CHECKSUM_EN
    csum_next = 32'h50320000;
`endif
    start_frame("f4", 32'd1);
    wait_done("f4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
